// File: rtl/aes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared definitions for the AES-128 control FSM. Both the next-state logic
// block and the sequential block (aes_ctrl_seq) import this package so they
// agree on state encodings, round count and mode encodings.
//   state_e   : S0..S9 state codes (4-bit); codes 10..15 are illegal
//   NR        : number of AES-128 rounds
//   ENC / DEC : values of the Select / Mode bit
//   is_legal  : true for codes S0..S9
// ---------------------------------------------------------------------------
package aes_ctrl_pkg;

    localparam int NR = 10;

    typedef enum logic [3:0] {
        S0 = 4'd0,   // idle
        S1 = 4'd1,   // encrypt: initial AddRoundKey (key 0)
        S2 = 4'd2,   // encrypt: rounds 1..9, then final round 10
        S3 = 4'd3,   // encrypt: bubble
        S4 = 4'd4,   // decrypt: setup
        S5 = 4'd5,   // decrypt: initial AddRoundKey (key 10)
        S6 = 4'd6,   // decrypt: inverse rounds 9..1
        S7 = 4'd7,   // decrypt: final inverse round (key 0)
        S8 = 4'd8,   // capture result
        S9 = 4'd9    // done
    } state_e;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    function automatic logic is_legal(input logic [3:0] code);
        return code <= S9;
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// ---------------------------------------------------------------------------
// aes_round_cnt
// Round counter / round-key index for the AES control FSM. The update is
// keyed by the current state code.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   q        in   current state code
//   clr      in   force the counter to zero on the next edge
//   count_q  out  registered round count
//   count_d  out  next round count (lets the parent register its strobes)
//   overrun  out  count has run past NR while in S2 (illegal condition)
// ---------------------------------------------------------------------------
module aes_round_cnt
    import aes_ctrl_pkg::*;
#(
    parameter int NR = aes_ctrl_pkg::NR,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] q,
    input  logic          clr,
    output logic [CW-1:0] count_q,
    output logic [CW-1:0] count_d,
    output logic          overrun
);

    localparam logic [CW-1:0] NR_C  = CW'(NR);
    localparam logic [CW-1:0] NR_M1 = CW'(NR - 1);

    assign overrun = (q == S2) && (count_q > NR_C);

    always_comb begin
        count_d = count_q;
        case (q)
            S0: count_d = '0;
            S1: count_d = CW'(1);
            S2: begin
                // Saturates at NR so the final round sees Count==NR.
                if (count_q < NR_C) begin
                    count_d = count_q + CW'(1);
                end
            end
            S4: count_d = NR_C;
            S5: count_d = NR_M1;
            S6: begin
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
            end
            S9: count_d = '0;
            default: count_d = count_q;   // S3, S7, S8 hold
        endcase
        // Illegal-state recovery takes priority over every update.
        if (clr || overrun) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aes_ctrl_seq.sv
// ---------------------------------------------------------------------------
// aes_ctrl_seq
// Sequential half of the AES-128 control FSM: state register, round
// counter and datapath strobe decode. Moore machine; every strobe is a flop
// whose next value is decoded from the next Q / Count, so the outputs are
// exactly the decode of the registered Q / Count with no output glitches.
//   Clk       in   system clock
//   Reset_n   in   asynchronous active-low reset
//   D         in   next-state code from the next-state logic
//   Start     in   start pulse, only honoured while Q==S0
//   Select    in   0=encrypt, 1=decrypt, captured with Start
//   Q         out  current state
//   Count     out  round counter / round-key index
//   Mode      out  captured Select
//   Load_En   out  initial AddRoundKey strobe
//   Round_En  out  full-round strobe
//   Final_En  out  final-round strobe
//   Out_Load  out  output-register capture strobe
//   Done      out  completion pulse
//   Busy      out  Q != S0
//   Illegal   out  one-cycle pulse after illegal-state recovery
// ---------------------------------------------------------------------------
module aes_ctrl_seq
#(
    parameter int NR = aes_ctrl_pkg::NR,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [CW-1:0] D,
    input  logic          Start,
    input  logic          Select,
    output logic [CW-1:0] Q,
    output logic [CW-1:0] Count,
    output logic          Mode,
    output logic          Load_En,
    output logic          Round_En,
    output logic          Final_En,
    output logic          Out_Load,
    output logic          Done,
    output logic          Busy,
    output logic          Illegal
);
    import aes_ctrl_pkg::*;

    localparam logic [CW-1:0] NR_C  = CW'(NR);
    localparam logic [CW-1:0] NR_M1 = CW'(NR - 1);

    logic [CW-1:0] q_q,        q_d;
    logic [CW-1:0] count_q,    count_d;
    logic          mode_q,     mode_d;
    logic          load_en_q,  load_en_d;
    logic          round_en_q, round_en_d;
    logic          final_en_q, final_en_d;
    logic          out_load_q, out_load_d;
    logic          done_q,     done_d;
    logic          busy_q,     busy_d;
    logic          illegal_q,  illegal_d;
    logic          d_illegal;
    logic          overrun;

    aes_round_cnt #(
        .NR (NR),
        .CW (CW)
    ) u_round_cnt (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .q       (q_q),
        .clr     (d_illegal),
        .count_q (count_q),
        .count_d (count_d),
        .overrun (overrun)
    );

    always_comb begin
        d_illegal = !is_legal(D);
        illegal_d = d_illegal || overrun;
        q_d       = illegal_d ? CW'(S0) : D;

        // Start is only meaningful in idle; later pulses leave Mode alone.
        mode_d = mode_q;
        if ((q_q == S0) && Start) begin
            mode_d = Select;
        end

        load_en_d  = (q_d == S1) || (q_d == S5);
        round_en_d = ((q_d == S2) && (count_d <= NR_M1)) || (q_d == S6);
        final_en_d = ((q_d == S2) && (count_d == NR_C)) || (q_d == S7);
        out_load_d = (q_d == S8);
        done_d     = (q_d == S9);
        busy_d     = (q_d != S0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_q        <= '0;
            mode_q     <= 1'b0;
            load_en_q  <= 1'b0;
            round_en_q <= 1'b0;
            final_en_q <= 1'b0;
            out_load_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            q_q        <= q_d;
            mode_q     <= mode_d;
            load_en_q  <= load_en_d;
            round_en_q <= round_en_d;
            final_en_q <= final_en_d;
            out_load_q <= out_load_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            illegal_q  <= illegal_d;
        end
    end

    assign Q        = q_q;
    assign Count    = count_q;
    assign Mode     = mode_q;
    assign Load_En  = load_en_q;
    assign Round_En = round_en_q;
    assign Final_En = final_en_q;
    assign Out_Load = out_load_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_ctrl_seq
// Directed bench for aes_ctrl_seq. Each operation replays a hand-written
// state/count timeline: D is driven with the next entry of that timeline,
// and after every edge the full output vector is compared against the
// expected entry.
// ---------------------------------------------------------------------------
module tb_aes_ctrl_seq;
    import aes_ctrl_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic [3:0] D;
    logic       Start;
    logic       Select;
    logic [3:0] Q;
    logic [3:0] Count;
    logic       Mode;
    logic       Load_En;
    logic       Round_En;
    logic       Final_En;
    logic       Out_Load;
    logic       Done;
    logic       Busy;
    logic       Illegal;

    int n_checks = 0;
    int n_fails  = 0;

    aes_ctrl_seq #(
        .NR (10),
        .CW (4)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .D        (D),
        .Start    (Start),
        .Select   (Select),
        .Q        (Q),
        .Count    (Count),
        .Mode     (Mode),
        .Load_En  (Load_En),
        .Round_En (Round_En),
        .Final_En (Final_En),
        .Out_Load (Out_Load),
        .Done     (Done),
        .Busy     (Busy),
        .Illegal  (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {Q, Count, Mode, Load, Round, Final, OutLoad, Done, Busy, Illegal}
    function automatic logic [15:0] obs();
        return {Q, Count, Mode, Load_En, Round_En, Final_En, Out_Load, Done, Busy, Illegal};
    endfunction

    function automatic logic [15:0] exp_vec(input int q, input int c, input logic m, input logic ill);
        logic [3:0] qq;
        logic [3:0] cc;
        logic ld, rd, fn, ol, dn, by;
        qq = 4'(q);
        cc = 4'(c);
        ld = (q == 1) || (q == 5);
        rd = ((q == 2) && (c <= 9)) || (q == 6);
        fn = ((q == 2) && (c == 10)) || (q == 7);
        ol = (q == 8);
        dn = (q == 9);
        by = (q != 0);
        return {qq, cc, m, ld, rd, fn, ol, dn, by, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got Q=%0d Cnt=%0d flags=%b, expected Q=%0d Cnt=%0d flags=%b",
                     tag, got[15:12], got[11:8], got[7:0], exp[15:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic tick(input logic [3:0] d, input logic st, input logic sel);
        D      = d;
        Start  = st;
        Select = sel;
        @(posedge Clk);
        #1;
    endtask

    // Runs one operation starting from an idle cycle (Q==S0).
    // glitch_at : cycle at which a stray Start with inverted Select is sent
    // abort_at  : cycle after which Reset_n is pulled low
    // illegal_at: cycle at which D is forced to 4'hC
    task automatic run_op(input string name, input logic sel,
                          input int glitch_at, input int abort_at, input int illegal_at);
        int eq[16];
        int ec[16];
        eq[0] = 0; ec[0] = 0;
        if (sel == ENC) begin
            eq[1] = 1; ec[1] = 0;
            for (int k = 2; k <= 11; k++) begin
                eq[k] = 2; ec[k] = k - 1;
            end
            eq[12] = 3; ec[12] = 10;
            eq[13] = 8; ec[13] = 10;
            eq[14] = 9; ec[14] = 10;
        end else begin
            eq[1] = 4; ec[1] = 0;
            eq[2] = 5; ec[2] = 10;
            for (int k = 3; k <= 11; k++) begin
                eq[k] = 6; ec[k] = 12 - k;
            end
            eq[12] = 7; ec[12] = 0;
            eq[13] = 8; ec[13] = 0;
            eq[14] = 9; ec[14] = 0;
        end
        eq[15] = 0; ec[15] = 0;

        for (int k = 0; k < 15; k++) begin
            logic [3:0] dn;
            dn = (k == illegal_at) ? 4'hC : 4'(eq[k+1]);
            tick(dn, (k == 0) || (k == glitch_at), (k == glitch_at) ? ~sel : sel);
            if (k == illegal_at) begin
                chk($sformatf("%s illegal c%0d", name, k + 1), obs(), exp_vec(0, 0, sel, 1'b1));
                tick(4'd0, 1'b0, 1'b0);
                chk($sformatf("%s illegal_clr", name), obs(), exp_vec(0, 0, sel, 1'b0));
                $display("op %s: illegal code injected at cycle %0d, recovered to idle", name, k);
                return;
            end
            chk($sformatf("%s c%0d", name, k + 1), obs(), exp_vec(eq[k+1], ec[k+1], sel, 1'b0));
            if (k + 1 == abort_at) begin
                D = 4'd0;
                Start = 1'b0;
                Reset_n = 1'b0;
                #1;
                chk($sformatf("%s async_reset", name), obs(), exp_vec(0, 0, 1'b0, 1'b0));
                @(posedge Clk);
                #1;
                chk($sformatf("%s reset_hold", name), obs(), exp_vec(0, 0, 1'b0, 1'b0));
                Reset_n = 1'b1;
                @(posedge Clk);
                #1;
                chk($sformatf("%s post_reset", name), obs(), exp_vec(0, 0, 1'b0, 1'b0));
                $display("op %s: aborted by reset after cycle %0d", name, k + 1);
                return;
            end
        end
        $display("op %s: mode=%0d completed, Done at cycle 14", name, sel);
    endtask

    initial begin
        Reset_n = 1'b1;
        D       = 4'd0;
        Start   = 1'b0;
        Select  = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("reset_async", obs(), exp_vec(0, 0, 1'b0, 1'b0));
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(4'd0, 1'b0, 1'b0);
            chk($sformatf("idle%0d", i), obs(), exp_vec(0, 0, 1'b0, 1'b0));
        end
        $display("op reset_idle: idle checked");

        run_op("enc0",      ENC, -1, -1, -1);
        run_op("dec_glitch", DEC, 5, -1, -1);   // stray Start while in S6
        run_op("enc_b2b",   ENC, -1, -1, -1);   // Start on first S0 after Done
        run_op("enc_abort", ENC, -1, 6, -1);    // reset in S2 with Count=5
        run_op("enc_after", ENC, -1, -1, -1);
        run_op("dec_ill",   DEC, -1, -1, 5);    // D=4'hC while in S6
        run_op("dec1",      DEC, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/aes_ctrl_seq.md
Name: aes_ctrl_seq

Overview:
- Sequential half of the AES-128 control FSM. It holds the state register and the round counter, and decodes the datapath strobes.
- Consumes the 4-bit next-state code from the next-state logic block. Returns the current state Q and the round count Count to that block.
- Drives load, round, final-round, output-capture and done strobes into the AES round datapath.
- Moore machine: all strobes are decoded from registered Q (and Count where stated).

Parameters:
- NR, 10, number of AES rounds. Sets the Count terminal value.
- CW, 4, width of Count and of the state code.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- D  in  4  next-state code from the next-state logic
- Start  in  1  start pulse; sampled only while Q==S0
- Select  in  1  0=encrypt, 1=decrypt; captured with Start
- Q  out  4  current state register
- Count  out  4  round counter / round-key index
- Mode  out  1  captured Select, held for the whole operation
- Load_En  out  1  initial AddRoundKey strobe
- Round_En  out  1  full-round strobe
- Final_En  out  1  final-round strobe (no MixColumns)
- Out_Load  out  1  capture result into the output register
- Done  out  1  one-cycle completion pulse
- Busy  out  1  high whenever Q!=S0
- Illegal  out  1  one-cycle pulse on illegal-state recovery

Behaviour:
- Clock and reset:
  - One clock (Clk).
  - Reset is asynchronous and active-low (Reset_n).
  - While Reset_n is low: Q=S0, Count=0, Mode=0, and every strobe reads 0.
  - Reset mid-operation aborts immediately. No Done is issued.
- State codes: S0..S9 = 0..9. Codes 10..15 are illegal.
- State register: Q <= D every cycle. If D>9, then Q <= S0, Count <= 0, and Illegal pulses next cycle.
- Mode capture: Mode <= Select when Q==S0 && Start==1. Mode is otherwise held.
- Start while Busy is ignored.
- Count update, by current Q:
  - S0: Count <= 0.
  - S1: Count <= 1.
  - S2: if Count<NR, Count <= Count+1. If Count==NR, hold. If Count>NR, force Q <= S0, Count <= 0, Illegal.
  - S3: hold.
  - S4: Count <= NR.
  - S5: Count <= NR-1.
  - S6: Count <= Count-1 when Count>0, else hold.
  - S7, S8: hold.
  - S9: Count <= 0.
- Strobe decode:
  - Load_En = (Q==S1) | (Q==S5).
  - Round_En = (Q==S2 && Count<=NR-1) | (Q==S6).
  - Final_En = (Q==S2 && Count==NR) | (Q==S7).
  - Out_Load = (Q==S8).
  - Done = (Q==S9).
  - Busy = (Q!=S0).
- Encrypt timeline (Start at cycle 0):
  - S1 with Count=0: Load_En, key 0.
  - S2 with Count 1..9: Round_En.
  - S2 with Count=10: Final_En.
  - S3: bubble.
  - S8: Out_Load.
  - S9: Done.
  - Latency is 14 cycles from Start sample to Done high.
- Decrypt timeline:
  - S4: setup.
  - S5 with Count=10: Load_En, key 10.
  - S6 with Count 9..1: Round_En, inverse rounds.
  - S7 with Count=0: Final_En.
  - S8: Out_Load.
  - S9: Done.
  - Latency is 14 cycles.
- Strobe exclusivity: at most one of Load_En, Round_En, Final_En, Out_Load and Done is high in any cycle.
- Back-to-back operation: Start may be asserted on the cycle Q returns to S0. There is no dead cycle beyond S0 itself.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state constants S0..S9 (4-bit);
  - NR=10;
  - mode encodings ENC=0, DEC=1.
- The package is shared with the next-state logic block.
- One natural sub-module: aes_round_cnt, holding the Count register and its load, increment and decrement logic keyed by Q.

Test Plan:
- Reset then idle, with D=0 and Start=0 -> Q=0, Count=0, Busy=0, all strobes 0.
- Encrypt: Start=1, Select=0 for one cycle, D driven by a reference next-state model -> Load_En at cycle 1 with Count=0; Round_En for 9 cycles with Count 1..9; Final_En with Count=10; Out_Load; Done at cycle 14; Mode=0 throughout.
- Decrypt: Start=1, Select=1 -> Load_En with Count=10; Round_En for 9 cycles with Count 9..1; Final_En with Count=0; Done at cycle 14; Mode=1.
- Reset_n low during S2 with Count=5 -> Q=0 and Count=0 asynchronously; no Done; a new Start then runs a full 14-cycle operation.
- Force D=4'hC while in S6 -> next cycle Q=0, Count=0, Illegal=1 for exactly one cycle, Busy=0.
- Start pulse while Q==S6 with Select toggled -> Mode unchanged, sequence unaffected; then Start on the first S0 cycle after Done -> new operation begins immediately.
